// File: rtl/eth_link_speed_detect_if.sv
// Link-speed detector signal bundle: RX prescaler toggle in, committed speed status out.
interface eth_link_speed_detect_if;
    logic       rx_prescale_msb;
    logic [1:0] speed;
    logic       mii_select;
    logic       speed_valid;
    logic       speed_change;
    logic       clk_lost;

    // Drives the RX toggle and observes the speed report (PHY side / bench).
    modport master (
        output rx_prescale_msb,
        input  speed,
        input  mii_select,
        input  speed_valid,
        input  speed_change,
        input  clk_lost
    );

    // The detector itself.
    modport slave (
        input  rx_prescale_msb,
        output speed,
        output mii_select,
        output speed_valid,
        output speed_change,
        output clk_lost
    );
endinterface

// File: rtl/eth_link_speed_detect.sv
// Ethernet link speed detector.
// Counts synchronised RX-prescaler edges against reference-clock windows. A short
// window (edge counter saturates first) means 100M or 1000M depending on how many
// reference cycles it took; a long window (reference counter saturates first) means
// 10M. A measurement only commits after STABLE_COUNT identical windows in a row, and
// a long quiet spell on the RX toggle drops speed_valid and raises clk_lost.
module eth_link_speed_detect #(
    parameter int REF_CNT_W    = 7,
    parameter int EDGE_CNT_W   = 2,
    parameter int THRESH_100M  = 32,
    parameter int STABLE_COUNT = 2,
    parameter int LOSS_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    eth_link_speed_detect_if.slave  link
);

    localparam logic [1:0] SPD_10M   = 2'b00;
    localparam logic [1:0] SPD_100M  = 2'b01;
    localparam logic [1:0] SPD_1000M = 2'b10;

    localparam int IDLE_W = $clog2(LOSS_CYCLES + 1);
    localparam int STAB_W = $clog2(STABLE_COUNT + 1);

    localparam logic [REF_CNT_W-1:0] THRESH   = REF_CNT_W'(THRESH_100M);
    localparam logic [IDLE_W-1:0]    LOSS_MAX = IDLE_W'(LOSS_CYCLES);
    localparam logic [STAB_W-1:0]    STAB_MAX = STAB_W'(STABLE_COUNT);

    // Reject parameter sets the counters cannot represent.
    generate
        if (THRESH_100M >= (1 << REF_CNT_W)) begin : g_bad_thresh
            $error("THRESH_100M must be below 2**REF_CNT_W");
        end
        if (STABLE_COUNT < 1) begin : g_bad_stable
            $error("STABLE_COUNT must be at least 1");
        end
        if (LOSS_CYCLES < 1) begin : g_bad_loss
            $error("LOSS_CYCLES must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clocks after rst_n rises
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // Two-flop release so every downstream flop leaves reset on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // RX toggle synchroniser and edge detect (both polarities count)
    // ------------------------------------------------------------------
    logic [2:0] sync_q;
    logic       rx_edge;

    // Three-flop chain; the last two stages compare for an edge.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) sync_q <= 3'b000;
        else            sync_q <= {sync_q[1:0], link.rx_prescale_msb};
    end

    assign rx_edge = sync_q[1] ^ sync_q[2];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [REF_CNT_W-1:0]  ref_cnt_q,  ref_cnt_d;
    logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                  clk_lost_q, clk_lost_d;
    logic [1:0]            cand_q,     cand_d;
    logic [STAB_W-1:0]     stab_q,     stab_d;
    logic [1:0]            speed_q,    speed_d;
    logic                  mii_q,      mii_d;
    logic                  valid_q,    valid_d;
    logic                  change_q,   change_d;

    // Window classification for the current cycle.
    logic       win_fast;
    logic       win_slow;
    logic       win_end;
    logic [1:0] meas;
    logic       commit;

    // Window end detection and measurement; the edge counter wins a tie.
    always_comb begin
        win_fast = &edge_cnt_q;
        win_slow = &ref_cnt_q;
        win_end  = (win_fast | win_slow) & ~clk_lost_q;
        if (win_fast) meas = (ref_cnt_q >= THRESH) ? SPD_100M : SPD_1000M;
        else          meas = SPD_10M;
    end

    // Loss-of-clock watchdog: saturating idle counter, cleared by any edge.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        clk_lost_d = clk_lost_q;
        if (rx_edge) begin
            idle_cnt_d = '0;
            clk_lost_d = 1'b0;
        end else begin
            if (idle_cnt_q != LOSS_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
            clk_lost_d = clk_lost_q | (idle_cnt_d == LOSS_MAX);
        end
    end

    // Window counters; held at zero while the clock is lost so the first
    // returning edge restarts both windows cleanly. An edge landing in the
    // window-end cycle is dropped.
    always_comb begin
        ref_cnt_d  = ref_cnt_q + 1'b1;
        edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(rx_edge);
        if (clk_lost_q || win_end) begin
            ref_cnt_d  = '0;
            edge_cnt_d = '0;
        end
    end

    // Hysteresis: count identical consecutive measurements, commit on reaching STABLE_COUNT.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        commit = 1'b0;
        if (clk_lost_q || clk_lost_d) begin
            stab_d = '0;
        end else if (win_end) begin
            if (meas == cand_q) begin
                stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
            end else begin
                cand_d = meas;
                stab_d = STAB_W'(1);
            end
            commit = (stab_d == STAB_MAX);
        end
    end

    // Reported status; speed/mii hold through a clock loss, only valid drops.
    always_comb begin
        speed_d  = speed_q;
        mii_d    = mii_q;
        valid_d  = valid_q;
        change_d = 1'b0;
        if (clk_lost_d) begin
            valid_d = 1'b0;
        end else if (commit) begin
            speed_d  = cand_d;
            mii_d    = (cand_d != SPD_1000M);
            valid_d  = 1'b1;
            change_d = (cand_d != speed_q) || !valid_q;
        end
    end

    // Measurement and hysteresis registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ref_cnt_q  <= '0;
            edge_cnt_q <= '0;
            idle_cnt_q <= '0;
            clk_lost_q <= 1'b0;
            cand_q     <= SPD_10M;
            stab_q     <= '0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            clk_lost_q <= clk_lost_d;
            cand_q     <= cand_d;
            stab_q     <= stab_d;
        end
    end

    // Output registers; out of reset the link is assumed gigabit but not valid.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            speed_q  <= SPD_1000M;
            mii_q    <= 1'b0;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            speed_q  <= speed_d;
            mii_q    <= mii_d;
            valid_q  <= valid_d;
            change_q <= change_d;
        end
    end

    assign link.speed        = speed_q;
    assign link.mii_select   = mii_q;
    assign link.speed_valid  = valid_q;
    assign link.speed_change = change_q;
    assign link.clk_lost     = clk_lost_q;

endmodule

// File: tb/tb_eth_link_speed_detect.sv
// Directed bench for eth_link_speed_detect: drives RX toggles at gigabit, 100M and
// 10M rates, a glitch window, a clock loss and a mid-window reset.
module tb_eth_link_speed_detect;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   pulses;

    eth_link_speed_detect_if link ();

    eth_link_speed_detect dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of clk cycles speed_change was seen high.
    always @(negedge clk) begin
        if (link.speed_change === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n toggles of the RX input, one every 'period' clk cycles.
    task automatic run_edges(input int period, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (period) @(posedge clk);
            #1 link.rx_prescale_msb = ~link.rx_prescale_msb;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        pulses = 0;
        rst_n  = 1'b0;
        link.rx_prescale_msb = 1'b0;

        // Reset state
        wait_cycles(3);
        chk("rst_speed",  32'(link.speed),        32'h2);
        chk("rst_mii",    32'(link.mii_select),   32'h0);
        chk("rst_valid",  32'(link.speed_valid),  32'h0);
        chk("rst_change", 32'(link.speed_change), 32'h0);
        chk("rst_lost",   32'(link.clk_lost),     32'h0);
        rst_n = 1'b1;

        // 1: gigabit, one window is not enough, two commit
        run_edges(4, 4);
        chk("g1_valid_w1", 32'(link.speed_valid), 32'h0);
        run_edges(4, 6);
        chk("g1_speed",  32'(link.speed),       32'h2);
        chk("g1_mii",    32'(link.mii_select),  32'h0);
        chk("g1_valid",  32'(link.speed_valid), 32'h1);
        chk("g1_pulses", 32'(pulses),           32'd1);

        // 2: 100M, speed holds for one window then moves
        run_edges(20, 3);
        chk("m100_hold_speed",  32'(link.speed), 32'h2);
        chk("m100_hold_pulses", 32'(pulses),     32'd1);
        run_edges(20, 3);
        chk("m100_speed",  32'(link.speed),       32'h1);
        chk("m100_mii",    32'(link.mii_select),  32'h1);
        chk("m100_valid",  32'(link.speed_valid), 32'h1);
        chk("m100_pulses", 32'(pulses),           32'd2);

        // 4: single gigabit-rate window inside 100M traffic is filtered
        run_edges(20, 1);
        run_edges(4, 2);
        chk("glitch_speed_mid", 32'(link.speed), 32'h1);
        run_edges(20, 9);
        chk("glitch_speed",  32'(link.speed),       32'h1);
        chk("glitch_valid",  32'(link.speed_valid), 32'h1);
        chk("glitch_pulses", 32'(pulses),           32'd2);

        // 3: 10M, reference windows end the measurement
        run_edges(200, 1);
        chk("m10_hold_speed", 32'(link.speed), 32'h1);
        run_edges(200, 2);
        chk("m10_speed",  32'(link.speed),       32'h0);
        chk("m10_mii",    32'(link.mii_select),  32'h1);
        chk("m10_valid",  32'(link.speed_valid), 32'h1);
        chk("m10_pulses", 32'(pulses),           32'd3);

        // 5: clock loss and recovery at gigabit
        wait_cycles(900);
        chk("loss_early_lost",  32'(link.clk_lost),    32'h0);
        chk("loss_early_valid", 32'(link.speed_valid), 32'h1);
        wait_cycles(200);
        chk("loss_lost",   32'(link.clk_lost),    32'h1);
        chk("loss_valid",  32'(link.speed_valid), 32'h0);
        chk("loss_speed",  32'(link.speed),       32'h0);
        chk("loss_mii",    32'(link.mii_select),  32'h1);
        chk("loss_pulses", 32'(pulses),           32'd3);
        run_edges(4, 2);
        chk("resume_lost",  32'(link.clk_lost),    32'h0);
        chk("resume_valid", 32'(link.speed_valid), 32'h0);
        run_edges(4, 4);
        chk("resume_valid_w1", 32'(link.speed_valid), 32'h0);
        run_edges(4, 4);
        chk("resume_speed",  32'(link.speed),       32'h2);
        chk("resume_mii",    32'(link.mii_select),  32'h0);
        chk("resume_valid2", 32'(link.speed_valid), 32'h1);
        chk("resume_pulses", 32'(pulses),           32'd4);

        // 6: reset mid-window with an RX edge between clock edges
        run_edges(4, 1);
        @(posedge clk);
        #3;
        link.rx_prescale_msb = ~link.rx_prescale_msb;
        rst_n = 1'b0;
        #1;
        chk("mrst_speed",  32'(link.speed),        32'h2);
        chk("mrst_mii",    32'(link.mii_select),   32'h0);
        chk("mrst_valid",  32'(link.speed_valid),  32'h0);
        chk("mrst_change", 32'(link.speed_change), 32'h0);
        chk("mrst_lost",   32'(link.clk_lost),     32'h0);
        wait_cycles(2);
        chk("mrst_hold_valid", 32'(link.speed_valid), 32'h0);
        rst_n = 1'b1;
        run_edges(4, 4);
        chk("mrst_valid_w1", 32'(link.speed_valid), 32'h0);
        run_edges(4, 4);
        chk("mrst_speed2",  32'(link.speed),       32'h2);
        chk("mrst_valid2",  32'(link.speed_valid), 32'h1);
        chk("mrst_pulses",  32'(pulses),           32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
